// File: rtl/axi_lite_regfile.sv
// AXI4-lite register file: DEPTH x 32-bit registers behind independent
// write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) state machines.
// AW and W may arrive in any order. A write commits on the edge where both
// channels have been captured.
// Optional build macro AXI_LITE_REGFILE_STRB_EN: honour wstrb byte lanes.
// Without it, all four bytes are always written.
module axi_lite_regfile #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [31:0]       r_regs [DEPTH];
  logic              r_aw_held, r_w_held;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;

  logic              w_aw_hs, w_w_hs, w_ar_hs;
  logic              w_commit;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata, w_bmask;
  logic [3:0]        w_wstrb;
  logic [IDX_W-1:0]  w_widx, w_ridx;
  logic              w_woor, w_roor;
  logic              w_unused;

  // Byte-offset bits are ignored; wstrb is only consumed in the strobe build
  assign w_unused = ^{awaddr[1:0], araddr[1:0], wstrb, r_wstrb};

  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_ar_hs = arvalid & arready;

  // Take each write field from the holding register if it was captured
  // earlier, otherwise straight from the bus (same-cycle capture).
  assign w_waddr = r_aw_held ? r_awaddr : awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : wstrb;

  assign w_commit = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  assign w_widx = w_waddr[IDX_W+1:2];
  assign w_woor = |w_waddr[ADDR_W-1:IDX_W+2];
  assign w_ridx = araddr[IDX_W+1:2];
  assign w_roor = |araddr[ADDR_W-1:IDX_W+2];

`ifdef AXI_LITE_REGFILE_STRB_EN
  assign w_bmask = {{8{w_wstrb[3]}}, {8{w_wstrb[2]}}, {8{w_wstrb[1]}}, {8{w_wstrb[0]}}};
`else
  assign w_bmask = 32'hFFFF_FFFF;
`endif

  // State registers for both FSMs
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // Next-state and handshake outputs; readies held low while in reset
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    awready      = 1'b0;
    wready       = 1'b0;
    arready      = 1'b0;
    bvalid       = 1'b0;
    rvalid       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        awready = ~areset & ~r_aw_held;
        wready  = ~areset & ~r_w_held;
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE: begin
        arready = ~areset;
        if (w_ar_hs) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Write-channel holding registers and response code
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (w_commit) r_bresp <= w_woor ? 2'b10 : 2'b00;
      if (bvalid && bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  // Register array; out-of-range writes are dropped
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_commit && !w_woor) begin
      r_regs[w_widx] <= (r_regs[w_widx] & ~w_bmask) | (w_wdata & w_bmask);
    end
  end

  // Read data capture; sees the pre-write value on a same-edge write
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (w_ar_hs) begin
      r_rdata <= w_roor ? 32'h0 : r_regs[w_ridx];
      r_rresp <= w_roor ? 2'b10 : 2'b00;
    end
  end

  assign bresp = r_bresp;
  assign rdata = r_rdata;
  assign rresp = r_rresp;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed scenarios plus a
// randomized mix, checked against an array model of the register file.
module tb_axi_lite_regfile;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
`ifdef AXI_LITE_REGFILE_STRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              areset;
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [DEPTH];

  axi_lite_regfile #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 aclk = ~aclk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = (s[b] || !STRB_EN) ? 8'hFF : 8'h00;
    if (a < DEPTH*4) mem[a/4] = (mem[a/4] & ~m) | (d & m);
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a < DEPTH*4) ? mem[a/4] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return (a < DEPTH*4) ? 2'b00 : 2'b10;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic apply_reset();
    areset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    repeat (3) @(posedge aclk);
    #1;
    model_reset();
  endtask

  // ok=0 on: early bvalid, ready re-raised for a held channel, late bvalid,
  // response or readies moving while bready is low.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_at, input int w_at, input int bdly,
                          output logic [1:0] resp, output bit ok);
    bit awd, wd, hs_aw, hs_w;
    int cyc;
    logic [1:0] r0;
    ok = 1; awd = 0; wd = 0; cyc = 0; resp = 2'bxx; r0 = 2'b00;
    awaddr = a; wdata = d; wstrb = s;
    while (!(awd && wd)) begin
      awvalid = !awd && (cyc >= aw_at);
      wvalid  = !wd && (cyc >= w_at);
      @(negedge aclk);
      if (bvalid) ok = 0;
      if ((awd && awready) || (wd && wready)) ok = 0;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk); #1;
      awd |= hs_aw; wd |= hs_w;
      cyc++;
      if (cyc > 100) begin
        total++; bad++;
        $display("FAIL write_handshake_timeout addr=%h got aw=%0d w=%0d want both", a, awd, wd);
        awvalid = 0; wvalid = 0; ok = 0;
        return;
      end
    end
    awvalid = 0; wvalid = 0; bready = 0;
    for (int i = 0; i < bdly; i++) begin
      @(negedge aclk);
      if (!bvalid || awready || wready) ok = 0;
      if (i == 0) r0 = bresp; else if (bresp !== r0) ok = 0;
      @(posedge aclk); #1;
    end
    bready = 1;
    @(negedge aclk);
    if (!bvalid) ok = 0;
    if (bdly > 0 && bresp !== r0) ok = 0;
    resp = bresp;
    @(posedge aclk); #1;
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly,
                         output logic [31:0] d, output logic [1:0] resp, output bit ok);
    bit hs;
    int cyc;
    logic [31:0] d0;
    logic [1:0] r0;
    ok = 1; cyc = 0; d = 'x; resp = 'x; d0 = '0; r0 = '0;
    araddr = a; arvalid = 1;
    while (1) begin
      @(negedge aclk);
      hs = arready;
      @(posedge aclk); #1;
      if (hs) break;
      cyc++;
      if (cyc > 100) begin
        total++; bad++;
        $display("FAIL read_handshake_timeout addr=%h got arready=0 want 1", a);
        arvalid = 0; ok = 0;
        return;
      end
    end
    arvalid = 0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge aclk);
      if (!rvalid || arready) ok = 0;
      if (i == 0) begin d0 = rdata; r0 = rresp; end
      else if (rdata !== d0 || rresp !== r0) ok = 0;
      @(posedge aclk); #1;
    end
    rready = 1;
    @(negedge aclk);
    if (!rvalid) ok = 0;
    if (rdly > 0 && (rdata !== d0 || rresp !== r0)) ok = 0;
    d = rdata; resp = rresp;
    @(posedge aclk); #1;
    rready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge aclk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h want all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      bad++;
      $display("FAIL reset_release got {aw,w,ar,b,r}=%b want 11100", {awready, wready, arready, bvalid, rvalid});
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] d; bit ok;
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, ok);
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    total++;
    if (!ok || resp !== 2'b00) begin bad++; $display("FAIL basic_write got ok=%0d bresp=%b want ok=1 bresp=00", ok, resp); end
    do_read(32'h4, 0, d, resp, ok);
    total++;
    if (!ok || d !== 32'hDEADBEEF || resp !== 2'b00) begin
      bad++; $display("FAIL basic_read got ok=%0d rdata=%h rresp=%b want ok=1 deadbeef 00", ok, d, resp);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic [31:0] d; bit ok;
    do_write(32'h8, 32'h12345678, 4'hF, 3, 0, 0, resp, ok);
    model_write(32'h8, 32'h12345678, 4'hF);
    total++;
    if (!ok || resp !== 2'b00) begin bad++; $display("FAIL w_first_write got ok=%0d bresp=%b want ok=1 bresp=00", ok, resp); end
    do_read(32'h8, 0, d, resp, ok);
    total++;
    if (!ok || d !== 32'h12345678) begin bad++; $display("FAIL w_first_read got ok=%0d rdata=%h want 12345678", ok, d); end
  endtask

  task automatic test_strb();
    logic [1:0] resp; logic [31:0] d, want; bit ok;
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, ok);
    model_write(32'h0, 32'hFFFFFFFF, 4'hF);
    do_write(32'h0, 32'h00000000, 4'h5, 0, 0, 0, resp, ok);
    model_write(32'h0, 32'h00000000, 4'h5);
    do_read(32'h0, 0, d, resp, ok);
    want = STRB_EN ? 32'hFF00FF00 : 32'h00000000;
    total++;
    if (!ok || d !== want || d !== model_rdata(32'h0)) begin
      bad++; $display("FAIL strobe_read got ok=%0d rdata=%h want %h", ok, d, want);
    end
  endtask

  task automatic test_oor();
    logic [1:0] resp; logic [31:0] d; bit ok, all_ok;
    do_write(32'h40, $urandom, 4'hF, 0, 0, 0, resp, ok);
    total++;
    if (!ok || resp !== 2'b10) begin bad++; $display("FAIL oor_write got ok=%0d bresp=%b want ok=1 bresp=10", ok, resp); end
    all_ok = 1;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i*4, 0, d, resp, ok);
      if (!ok || d !== mem[i] || resp !== 2'b00) begin
        all_ok = 0;
        $display("reg %0d read %h expected %h", i, d, mem[i]);
      end
    end
    total++;
    if (!all_ok) begin bad++; $display("FAIL oor_regs_unchanged got some_changed=1 want 0"); end
    do_read(32'h40, 0, d, resp, ok);
    total++;
    if (!ok || d !== 32'h0 || resp !== 2'b10) begin
      bad++; $display("FAIL oor_read got ok=%0d rdata=%h rresp=%b want 00000000 10", ok, d, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [31:0] d, v; bit ok;
    v = $urandom;
    do_write(32'h14, v, 4'hF, 0, 0, 5, resp, ok);
    model_write(32'h14, v, 4'hF);
    total++;
    if (!ok || resp !== 2'b00) begin bad++; $display("FAIL bready_stall got ok=%0d bresp=%b want ok=1 bresp=00", ok, resp); end
    do_read(32'h14, 5, d, resp, ok);
    total++;
    if (!ok || d !== model_rdata(32'h14)) begin bad++; $display("FAIL rready_stall got ok=%0d rdata=%h want %h", ok, d, model_rdata(32'h14)); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [31:0] d, v0, v1; bit ok, ok1;
    v0 = $urandom; v1 = $urandom;
    do_write(32'h18, v0, 4'hF, 0, 0, 0, resp, ok);
    model_write(32'h18, v0, 4'hF);
    @(negedge aclk);
    total++;
    if (!(awready && wready)) begin bad++; $display("FAIL b2b_ready got aw=%b w=%b want 1 1", awready, wready); end
    @(posedge aclk); #1;
    do_write(32'h1C, v1, 4'hF, 0, 0, 0, resp, ok1);
    model_write(32'h1C, v1, 4'hF);
    do_read(32'h18, 0, d, resp, ok);
    total++;
    if (!ok || !ok1 || d !== model_rdata(32'h18)) begin bad++; $display("FAIL b2b_first got rdata=%h want %h", d, model_rdata(32'h18)); end
    do_read(32'h1C, 0, d, resp, ok);
    total++;
    if (!ok || d !== model_rdata(32'h1C)) begin bad++; $display("FAIL b2b_second got rdata=%h want %h", d, model_rdata(32'h1C)); end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp; logic [31:0] d, vb, old; bit ok;
    do_write(32'h20, 32'hA5A5_0001, 4'hF, 0, 0, 0, resp, ok);
    model_write(32'h20, 32'hA5A5_0001, 4'hF);
    old = model_rdata(32'h20);
    vb = 32'h5A5A_0002;
    awaddr = 32'h20; wdata = vb; wstrb = 4'hF; araddr = 32'h20;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge aclk);
    total++;
    if (!(awready && wready && arready)) begin bad++; $display("FAIL same_cycle_ready got aw=%b w=%b ar=%b want 111", awready, wready, arready); end
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge aclk);
    total++;
    if (!bvalid || !rvalid || rdata !== old) begin
      bad++; $display("FAIL same_cycle_read got b=%b r=%b rdata=%h want 1 1 %h", bvalid, rvalid, rdata, old);
    end
    model_write(32'h20, vb, 4'hF);
    bready = 1; rready = 1;
    @(posedge aclk); #1;
    bready = 0; rready = 0;
    do_read(32'h20, 0, d, resp, ok);
    total++;
    if (!ok || d !== vb) begin bad++; $display("FAIL same_cycle_after got rdata=%h want %h", d, vb); end
  endtask

  task automatic test_hold();
    logic [1:0] resp; logic [31:0] d, v; bit ok, quiet; int cyc;
    v = $urandom;
    wdata = v; wstrb = 4'hF; wvalid = 1; awvalid = 0;
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (bvalid || (i > 0 && wready)) quiet = 0;
      @(posedge aclk); #1;
      wvalid = 0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL w_only_hold got side_effect=1 want 0"); end
    do_read(32'h24, 0, d, resp, ok);
    total++;
    if (!ok || d !== model_rdata(32'h24)) begin bad++; $display("FAIL w_only_no_commit got rdata=%h want %h", d, model_rdata(32'h24)); end
    awaddr = 32'h24; awvalid = 1; cyc = 0;
    while (1) begin
      @(negedge aclk);
      ok = awready;
      @(posedge aclk); #1;
      if (ok || ++cyc > 50) break;
    end
    awvalid = 0;
    model_write(32'h24, v, 4'hF);
    @(negedge aclk);
    total++;
    if (!bvalid || bresp !== 2'b00) begin bad++; $display("FAIL w_only_complete got bvalid=%b bresp=%b want 1 00", bvalid, bresp); end
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    do_read(32'h24, 0, d, resp, ok);
    total++;
    if (!ok || d !== v) begin bad++; $display("FAIL w_only_readback got rdata=%h want %h", d, v); end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] a, d, v; logic [3:0] s; bit ok; int errs;
    errs = 0;
    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, DEPTH*4 + 15);
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom; s = 4'($urandom);
        do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, ok);
        model_write(a, v, s);
        total++;
        if (!ok || resp !== model_resp(a)) begin
          bad++; errs++; $display("FAIL rand_write addr=%h got ok=%0d bresp=%b want ok=1 bresp=%b", a, ok, resp, model_resp(a));
        end
      end else begin
        do_read(a, $urandom_range(0, 2), d, resp, ok);
        total++;
        if (!ok || d !== model_rdata(a) || resp !== model_resp(a)) begin
          bad++; errs++; $display("FAIL rand_read addr=%h got ok=%0d rdata=%h rresp=%b want %h %b", a, ok, d, resp, model_rdata(a), model_resp(a));
        end
      end
      if (errs > 10) break;
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; bit ok;
    awaddr = 32'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    total++;
    if (!bvalid) begin bad++; $display("FAIL mid_reset_pre got bvalid=0 want 1"); end
    areset = 1;
    @(posedge aclk); #1;
    @(negedge aclk);
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_reset_bvalid got bvalid=%b want 0", bvalid); end
    areset = 0;
    model_reset();
    @(posedge aclk); #1;
    do_read(32'hC, 0, d, resp, ok);
    total++;
    if (!ok || d !== 32'h0) begin bad++; $display("FAIL mid_reset_readback got rdata=%h want 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first();
    test_strb();
    test_oor();
    test_backpressure();
    test_back_to_back();
    test_same_cycle();
    test_hold();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
